// File: rtl/board_input_conditioner.sv
// Board KEY/SW input conditioning: sync, debounce, edge capture, level irq.
// Define BIC_KEY_ACTIVE_HIGH_EN to invert key polarity after the synchroniser.
module board_input_conditioner #(
  parameter int W_KEY          = 4,
  parameter int W_SW           = 18,
  parameter int TICK_CYCLES    = 50000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [W_KEY-1:0]        key_raw,
  input  logic [W_SW-1:0]         sw_raw,
  input  logic [W_KEY+W_SW-1:0]   rise_en,
  input  logic [W_KEY+W_SW-1:0]   fall_en,
  input  logic [W_KEY+W_SW-1:0]   irq_mask,
  input  logic                    clr_valid,
  input  logic [W_KEY+W_SW-1:0]   clr_mask,
  output logic [31:0]             gpio_in,
  output logic [W_KEY+W_SW-1:0]   edge_stat,
  output logic                    irq
);

  localparam int N  = W_KEY + W_SW;
  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] TMAX = CW'(TICK_CYCLES - 1);
  localparam logic [N-1:0] SYNC_RST = {{W_KEY{1'b1}}, {W_SW{1'b0}}};

`ifdef BIC_KEY_ACTIVE_HIGH_EN
  localparam logic [N-1:0] KEY_INV = {{W_KEY{1'b1}}, {W_SW{1'b0}}};
  localparam logic [N-1:0] DB_RST  = '0;
`else
  localparam logic [N-1:0] KEY_INV = '0;
  localparam logic [N-1:0] DB_RST  = SYNC_RST;
`endif

  logic          r_rst_meta;
  logic          r_rst_n;
  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_tick_d;
  logic [N-1:0]  r_hist [STABLE_SAMPLES];
  logic [N-1:0]  r_db;
  logic [N-1:0]  r_edge;
  logic          r_irq;

  logic          w_tick;
  logic [N-1:0]  w_samp;
  logic [N-1:0]  w_all1;
  logic [N-1:0]  w_all0;
  logic [N-1:0]  w_db_nxt;
  logic [N-1:0]  w_rise;
  logic [N-1:0]  w_fall;
  logic [N-1:0]  w_set;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_stat_nxt;
  logic [31:0]   w_gpio;

  // Async assert, clk-synchronous release of the internal reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_sync1 <= SYNC_RST;
      r_sync2 <= SYNC_RST;
    end else begin
      r_sync1 <= {key_raw, sw_raw};
      r_sync2 <= r_sync1;
    end
  end

  assign w_samp = r_sync2 ^ KEY_INV;
  assign w_tick = (r_cnt == TMAX);

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_cnt    <= '0;
      r_tick_d <= 1'b0;
    end else begin
      r_cnt    <= w_tick ? '0 : r_cnt + 1'b1;
      r_tick_d <= w_tick;
    end
  end

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      for (int k = 0; k < STABLE_SAMPLES; k++)
        r_hist[k] <= DB_RST;
    end else if (w_tick) begin
      r_hist[0] <= w_samp;
      for (int k = 1; k < STABLE_SAMPLES; k++)
        r_hist[k] <= r_hist[k-1];
    end
  end

  always_comb begin
    w_all1 = '1;
    w_all0 = '1;
    for (int k = 0; k < STABLE_SAMPLES; k++) begin
      w_all1 = w_all1 & r_hist[k];
      w_all0 = w_all0 & ~r_hist[k];
    end
  end

  // A bit moves only when its whole history agrees
  assign w_db_nxt = r_tick_d ? ((r_db | w_all1) & ~w_all0) : r_db;

  assign w_rise     = w_db_nxt & ~r_db;
  assign w_fall     = ~w_db_nxt & r_db;
  assign w_set      = (w_rise & rise_en) | (w_fall & fall_en);
  assign w_clr      = clr_valid ? clr_mask : '0;
  assign w_stat_nxt = w_set | (r_edge & ~w_clr);

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_db   <= DB_RST;
      r_edge <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_db   <= w_db_nxt;
      r_edge <= w_stat_nxt;
      r_irq  <= |(r_edge & irq_mask);
    end
  end

  always_comb begin
    w_gpio        = '0;
    w_gpio[N-1:0] = r_db;
  end

  assign gpio_in   = w_gpio;
  assign edge_stat = r_edge;
  assign irq       = r_irq;

endmodule
